// File: rtl/edge_evt_pkg.sv
// Shared types and helpers for the edge event arbiter.
// Channel index width is derived here so the interface and the bench stay in step.
package edge_evt_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/edge_event_arbiter_if.sv
// Downstream event port: one offered channel index with valid/ready handshake.
// The arbiter drives the master side; the consumer drives evt_ready.
interface edge_event_arbiter_if #(
    parameter int ID_W = 2
);
    logic            evt_valid;
    logic            evt_ready;
    logic [ID_W-1:0] evt_id;

    modport master (output evt_valid, output evt_id, input evt_ready);
    modport slave  (input evt_valid, input evt_id, output evt_ready);
endinterface

// File: rtl/edge_event_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after start, wrapping.
// No latency; start must be below NUM_CH.
module rr_pick #(
    parameter int NUM_CH = 4,
    parameter int ID_W   = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [ID_W-1:0]   start,
    output logic              found,
    output logic [ID_W-1:0]   winner
);

    always_comb begin
        int idx;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = int'(start) + k;
            // explicit wrap keeps non-power-of-2 channel counts correct
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/edge_event_arbiter.sv
// Rising-edge capture into per-channel pending bits, round-robin onto one valid/ready port.
// Rise to evt_valid is two edges when idle; back-to-back offers without bubbles; edges on a stalled pending channel are counted as drops.
module edge_event_arbiter
    import edge_evt_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8,
    localparam int ID_W  = id_width(NUM_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_CH-1:0]     in_level,
    edge_event_arbiter_if.master  evt,
    output logic [NUM_CH-1:0]     pending,
    output logic [CNT_W-1:0]      drop_count
);

    localparam int SUM_W = CNT_W + ID_W + 1;

    state_t              state_q, state_d;
    logic                valid_q, valid_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [ID_W-1:0]     rr_ptr, rr_ptr_d;
    logic [NUM_CH-1:0]   prev_level;
    logic [NUM_CH-1:0]   rise, clear, drop, pending_d;
    logic                hs;
    logic [ID_W:0]       n_drop;
    logic [SUM_W-1:0]    drop_sum;
    logic [CNT_W-1:0]    drop_d;
    logic [NUM_CH-1:0]   pick_req;
    logic [ID_W-1:0]     pick_start;
    logic                pick_found;
    logic [ID_W-1:0]     pick_winner;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
        return (int'(v) == NUM_CH - 1) ? '0 : v + 1'b1;
    endfunction

    assign evt.evt_valid = valid_q;
    assign evt.evt_id    = id_q;
    assign hs            = valid_q & evt.evt_ready;
    assign rise          = in_level & ~prev_level;

    always_comb begin
        clear  = '0;
        n_drop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            clear[i] = hs && (id_q == ID_W'(i));
        end
        // a rise coinciding with its own clear re-arms the channel rather than dropping
        drop      = rise & pending & ~clear;
        pending_d = rise | (pending & ~clear);
        for (int i = 0; i < NUM_CH; i++) begin
            n_drop = n_drop + (ID_W+1)'(drop[i]);
        end
        drop_sum = {{(ID_W+1){1'b0}}, drop_count} + {{CNT_W{1'b0}}, n_drop};
        drop_d   = (drop_sum > {{(ID_W+1){1'b0}}, {CNT_W{1'b1}}}) ? '1 : drop_sum[CNT_W-1:0];
    end

    // the picker only ever sees registered pending bits
    assign pick_req   = (state_q == OFFER) ? (pending & ~clear) : pending;
    assign pick_start = (state_q == OFFER) ? wrap_inc(id_q) : rr_ptr;

    rr_pick #(.NUM_CH(NUM_CH), .ID_W(ID_W)) u_pick (
        .req    (pick_req),
        .start  (pick_start),
        .found  (pick_found),
        .winner (pick_winner)
    );

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        id_d     = id_q;
        rr_ptr_d = rr_ptr;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                if (pick_found) begin
                    id_d    = pick_winner;
                    valid_d = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (hs) begin
                    rr_ptr_d = wrap_inc(id_q);
                    if (pick_found) begin
                        id_d = pick_winner;
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            valid_q    <= 1'b0;
            id_q       <= '0;
            rr_ptr     <= '0;
            prev_level <= '0;
            pending    <= '0;
            drop_count <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            id_q       <= id_d;
            rr_ptr     <= rr_ptr_d;
            prev_level <= in_level;
            pending    <= pending_d;
            drop_count <= drop_d;
        end
    end

endmodule
